// File: rtl/piece_controller.sv
// piece_controller: falling-tetromino engine (spawn, move, rotate, gravity, lock, commit); define HARD_DROP_EN to add hard drop.
// All outputs registered, one cycle after the sampled inputs; no backpressure, pulse inputs are acted on or dropped.
module piece_controller #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int SPAWN_COL = 3
) (
  input  logic                   clka,
  input  logic                   reset_n,
  input  logic [2:0]             state,
  input  logic [2:0]             piece_type_in,
  input  logic [ROWS*COLS-1:0]   board_occ,
  input  logic                   tick,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_rot,
  input  logic                   btn_drop,
  output logic                   placed,
  output logic                   game_over,
  output logic                   commit,
  output logic [ROWS*COLS-1:0]   commit_mask,
  output logic                   piece_valid,
  output logic [2:0]             piece_type,
  output logic [1:0]             piece_rot,
  output logic [4:0]             piece_row,
  output logic signed [5:0]      piece_col
);

  localparam int NCELL = ROWS * COLS;
  localparam int IW    = $clog2(NCELL);

  localparam logic [2:0] GS_GEN      = 3'd0;
  localparam logic [2:0] GS_MOVE     = 3'd1;
  localparam logic [2:0] GS_LAND     = 3'd2;
  localparam logic [2:0] GS_NEWBOARD = 3'd4;
  localparam logic [2:0] GS_GAMEOVER = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_CHECK,
    S_ACTIVE,
    S_LOCKED,
    S_DEAD
`ifdef HARD_DROP_EN
    , S_DROP
`endif
  } pst_t;

  // 4x4 bitmap, bit (r*4 + c) = cell at bitmap row r, column c; type 7 falls to O
  function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] r);
    logic [15:0] s;
    case ({t, r})
      5'd0:  s = 16'h00F0;  5'd1:  s = 16'h4444;  5'd2:  s = 16'h0F00;  5'd3:  s = 16'h2222;
      5'd8:  s = 16'h0072;  5'd9:  s = 16'h0262;  5'd10: s = 16'h0270;  5'd11: s = 16'h0232;
      5'd12: s = 16'h0036;  5'd13: s = 16'h0462;  5'd14: s = 16'h0360;  5'd15: s = 16'h0231;
      5'd16: s = 16'h0063;  5'd17: s = 16'h0264;  5'd18: s = 16'h0630;  5'd19: s = 16'h0132;
      5'd20: s = 16'h0071;  5'd21: s = 16'h0226;  5'd22: s = 16'h0470;  5'd23: s = 16'h0322;
      5'd24: s = 16'h0074;  5'd25: s = 16'h0622;  5'd26: s = 16'h0170;  5'd27: s = 16'h0223;
      default: s = 16'h0066;
    endcase
    return s;
  endfunction

  function automatic logic collide(input logic [15:0] shp, input int row, input int col,
                                   input logic [NCELL-1:0] occ);
    logic hit;
    int   br;
    int   bc;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      br = row + i / 4;
      bc = col + i % 4;
      if (shp[4'(i)]) begin
        if (br < 0 || br >= ROWS || bc < 0 || bc >= COLS) hit = 1'b1;
        else if (occ[IW'(br * COLS + bc)])                 hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic logic [NCELL-1:0] piece_mask(input logic [15:0] shp, input int row, input int col);
    logic [NCELL-1:0] m;
    int br;
    int bc;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      br = row + i / 4;
      bc = col + i % 4;
      if (shp[4'(i)] && br >= 0 && br < ROWS && bc >= 0 && bc < COLS) m[IW'(br * COLS + bc)] = 1'b1;
    end
    return m;
  endfunction

  pst_t               st_q, st_d;
  logic [2:0]         type_q, type_d;
  logic [1:0]         rot_q, rot_d;
  logic [4:0]         row_q, row_d;
  logic signed [5:0]  col_q, col_d;
  logic               placed_q, placed_d;
  logic               go_q, go_d;
  logic               valid_q, valid_d;
  logic               pend_q, pend_d;
  logic               commit_q, commit_d;
  logic [NCELL-1:0]   mask_q, mask_d;

  logic [1:0]         cand_rot;
  int                 cand_row;
  int                 cand_col;
  logic               hit;
  logic               grav;
  logic               btn_any;

`ifndef HARD_DROP_EN
  logic unused_btn_drop;
  assign unused_btn_drop = btn_drop;
`endif

  always_comb begin
    st_d     = st_q;
    type_d   = type_q;
    rot_d    = rot_q;
    row_d    = row_q;
    col_d    = col_q;
    placed_d = placed_q;
    go_d     = go_q;
    valid_d  = valid_q;
    pend_d   = pend_q;
    commit_d = 1'b0;
    mask_d   = '0;
    grav     = tick | pend_q;
    btn_any  = btn_rot | btn_left | btn_right;

    // One candidate pose per cycle, so a single collision check serves every action
    cand_rot = rot_q;
    cand_row = int'(row_q);
    cand_col = int'(col_q);
    if (st_q == S_ACTIVE) begin
      if (btn_rot)        cand_rot = rot_q + 2'd1;
      else if (btn_left)  cand_col = cand_col - 1;
      else if (btn_right) cand_col = cand_col + 1;
      else if (grav)      cand_row = cand_row + 1;
    end
`ifdef HARD_DROP_EN
    if (st_q == S_DROP) cand_row = cand_row + 1;
`endif
    hit = collide(shape(type_q, cand_rot), cand_row, cand_col, board_occ);

    case (st_q)
      S_IDLE, S_LOCKED: begin
        if (state == GS_GEN) begin
          type_d   = (piece_type_in == 3'd7) ? 3'd1 : piece_type_in;
          rot_d    = 2'd0;
          row_d    = 5'd0;
          col_d    = 6'(SPAWN_COL);
          placed_d = 1'b0;
          pend_d   = 1'b0;
          valid_d  = 1'b0;
          st_d     = S_SPAWN;
        end else if (st_q == S_LOCKED && state == GS_LAND) begin
          commit_d = 1'b1;
          mask_d   = piece_mask(shape(type_q, rot_q), int'(row_q), int'(col_q));
          valid_d  = 1'b0;
          st_d     = S_IDLE;
        end
      end
      S_SPAWN: st_d = S_CHECK;
      S_CHECK: begin
        if (hit) begin
          st_d = S_DEAD;
          go_d = 1'b1;
        end else begin
          st_d    = S_ACTIVE;
          valid_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (state == GS_MOVE) begin
`ifdef HARD_DROP_EN
          if (btn_drop) begin
            st_d   = S_DROP;
            pend_d = 1'b0;
          end else
`endif
          if (btn_any) begin
            if (!hit) begin
              rot_d = cand_rot;
              col_d = 6'(cand_col);
            end
            if (tick) pend_d = 1'b1;
          end else if (grav) begin
            pend_d = 1'b0;
            if (!hit) begin
              row_d = 5'(cand_row);
            end else begin
              st_d     = S_LOCKED;
              placed_d = 1'b1;
            end
          end
        end
      end
`ifdef HARD_DROP_EN
      S_DROP: begin
        if (state != GS_GAMEOVER) begin
          if (!hit) begin
            row_d = 5'(cand_row);
          end else begin
            st_d     = S_LOCKED;
            placed_d = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase

    if (state == GS_NEWBOARD) begin
      st_d     = S_IDLE;
      go_d     = 1'b0;
      placed_d = 1'b0;
      valid_d  = 1'b0;
      pend_d   = 1'b0;
      commit_d = 1'b0;
      mask_d   = '0;
    end
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= S_IDLE;
      type_q   <= 3'd0;
      rot_q    <= 2'd0;
      row_q    <= 5'd0;
      col_q    <= 6'(SPAWN_COL);
      placed_q <= 1'b0;
      go_q     <= 1'b0;
      valid_q  <= 1'b0;
      pend_q   <= 1'b0;
      commit_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      st_q     <= st_d;
      type_q   <= type_d;
      rot_q    <= rot_d;
      row_q    <= row_d;
      col_q    <= col_d;
      placed_q <= placed_d;
      go_q     <= go_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      mask_q   <= mask_d;
    end
  end

  assign placed      = placed_q;
  assign game_over   = go_q;
  assign commit      = commit_q;
  assign commit_mask = mask_q;
  assign piece_valid = valid_q;
  assign piece_type  = type_q;
  assign piece_rot   = rot_q;
  assign piece_row   = row_q;
  assign piece_col   = col_q;

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: table of per-cycle vectors plus hand sequences for lock/commit, game over and reset.
module tb_piece_controller;

  localparam logic [2:0] GEN = 3'd0, MV = 3'd1, LAND = 3'd2, IDL = 3'd3, NB = 3'd4, GO = 3'd5;

  logic               clka = 1'b0;
  logic               reset_n;
  logic [2:0]         game_state;
  logic [2:0]         ptype;
  logic [199:0]       occ;
  logic               tick, btn_left, btn_right, btn_rot, btn_drop;
  logic               placed, game_over, commit, piece_valid;
  logic [199:0]       commit_mask;
  logic [2:0]         piece_type;
  logic [1:0]         piece_rot;
  logic [4:0]         piece_row;
  logic signed [5:0]  piece_col;

  int checks   = 0;
  int failures = 0;

  piece_controller dut (
    .clka(clka), .reset_n(reset_n), .state(game_state), .piece_type_in(ptype), .board_occ(occ),
    .tick(tick), .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
    .placed(placed), .game_over(game_over), .commit(commit), .commit_mask(commit_mask),
    .piece_valid(piece_valid), .piece_type(piece_type), .piece_rot(piece_rot),
    .piece_row(piece_row), .piece_col(piece_col)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [2:0] gs;
    logic [2:0] pt;
    logic       tk, bl, br, brt;
    logic       cp;
    logic       ev;
    int         er, ec, erot, ety;
    logic       ep, ego;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [2:0] gs, input logic [2:0] pt, input logic tk, input logic bl,
                     input logic br, input logic brt, input logic cp, input logic ev, input int er,
                     input int ec, input int erot, input int ety, input logic ep, input logic ego);
    vec_t v;
    v.gs = gs; v.pt = pt; v.tk = tk; v.bl = bl; v.br = br; v.brt = brt; v.cp = cp; v.ev = ev;
    v.er = er; v.ec = ec; v.erot = erot; v.ety = ety; v.ep = ep; v.ego = ego;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_mask(input string nm, input logic [199:0] exp);
    checks++;
    if (commit_mask !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, commit_mask, exp);
    end
  endtask

  task automatic drive(input logic [2:0] gs, input logic [2:0] pt, input logic tk, input logic bl,
                       input logic br, input logic brt, input logic bd);
    game_state = gs; ptype = pt; tick = tk; btn_left = bl; btn_right = br; btn_rot = brt; btn_drop = bd;
    @(posedge clka);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_placed"}, int'(placed), 0);
    chk({tag, "_go"}, int'(game_over), 0);
    chk({tag, "_commit"}, int'(commit), 0);
    chk({tag, "_valid"}, int'(piece_valid), 0);
    chk({tag, "_type"}, int'(piece_type), 0);
    chk({tag, "_rot"}, int'(piece_rot), 0);
    chk({tag, "_row"}, int'(piece_row), 0);
    chk({tag, "_col"}, int'(piece_col), 3);
    chk_mask({tag, "_mask"}, '0);
  endtask

  logic [199:0] em;

  initial begin
    reset_n = 1'b0; game_state = IDL; ptype = 3'd0; occ = '0;
    tick = 0; btn_left = 0; btn_right = 0; btn_rot = 0; btn_drop = 0;

    // ---- table: T spawn/moves/pending gravity, GAMEOVER freeze, I walls, type 7 as O
    //  gs   pt tk bl br rt  cp ev row col rot ty  pl go
    add(GEN, 2, 0, 0, 0, 0,  1, 0, 0,  3,  0,  2,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 0, 0,  3,  0,  2,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 1, 0,  3,  0,  2,  0, 0);
    add(MV,  0, 1, 0, 1, 0,  1, 1, 0,  4,  0,  2,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 1, 1,  4,  0,  2,  0, 0);
    add(MV,  0, 1, 0, 1, 0,  1, 1, 1,  5,  0,  2,  0, 0);
    add(MV,  0, 1, 1, 0, 0,  1, 1, 1,  4,  0,  2,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 1, 2,  4,  0,  2,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 1, 2,  4,  0,  2,  0, 0);
    add(MV,  0, 0, 0, 0, 1,  1, 1, 2,  4,  1,  2,  0, 0);
    add(MV,  0, 1, 0, 0, 0,  1, 1, 3,  4,  1,  2,  0, 0);
    add(GO,  0, 1, 1, 0, 0,  1, 1, 3,  4,  1,  2,  0, 0);
    add(NB,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0,  0, 0);
    add(GEN, 0, 0, 0, 0, 0,  1, 0, 0,  3,  0,  0,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 0, 0,  3,  0,  0,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 1, 0,  3,  0,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0,  2,  0,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0,  1,  0,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0,  0,  0,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0,  0,  0,  0,  0, 0);
    add(MV,  0, 0, 0, 0, 1,  1, 1, 0,  0,  1,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0, -1,  1,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0, -2,  1,  0,  0, 0);
    add(MV,  0, 0, 1, 0, 0,  1, 1, 0, -2,  1,  0,  0, 0);
    add(MV,  0, 0, 0, 0, 1,  1, 1, 0, -2,  1,  0,  0, 0);
    add(MV,  0, 0, 0, 1, 0,  1, 1, 0, -1,  1,  0,  0, 0);
    add(MV,  0, 0, 0, 0, 1,  1, 1, 0, -1,  1,  0,  0, 0);
    add(MV,  0, 0, 0, 1, 0,  1, 1, 0,  0,  1,  0,  0, 0);
    add(MV,  0, 0, 0, 0, 1,  1, 1, 0,  0,  2,  0,  0, 0);
    add(NB,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0,  0, 0);
    add(GEN, 7, 0, 0, 0, 0,  1, 0, 0,  3,  0,  1,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 0, 0,  3,  0,  1,  0, 0);
    add(MV,  0, 0, 0, 0, 0,  1, 1, 0,  3,  0,  1,  0, 0);
    add(NB,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0,  0, 0);

    #12;
    chk_reset_vals("reset");
    @(negedge clka);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].gs, vt[i].pt, vt[i].tk, vt[i].bl, vt[i].br, vt[i].brt, 1'b0);
      chk($sformatf("v%0d_valid", i), int'(piece_valid), int'(vt[i].ev));
      if (vt[i].cp) begin
        chk($sformatf("v%0d_row", i), int'(piece_row), vt[i].er);
        chk($sformatf("v%0d_col", i), int'(piece_col), vt[i].ec);
        chk($sformatf("v%0d_rot", i), int'(piece_rot), vt[i].erot);
        chk($sformatf("v%0d_type", i), int'(piece_type), vt[i].ety);
      end
      chk($sformatf("v%0d_placed", i), int'(placed), int'(vt[i].ep));
      chk($sformatf("v%0d_go", i), int'(game_over), int'(vt[i].ego));
    end

    // ---- O piece: 18 ticks to the floor, 19th locks, LAND commits once
    drive(GEN, 3'd1, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    chk("o_valid", int'(piece_valid), 1);
    for (int k = 0; k < 18; k++) drive(MV, 0, 1, 0, 0, 0, 0);
    chk("o_row18", int'(piece_row), 18);
    chk("o_not_placed", int'(placed), 0);
    drive(MV, 0, 1, 0, 0, 0, 0);
    chk("o_placed", int'(placed), 1);
    chk("o_row_hold", int'(piece_row), 18);
    chk("o_no_commit_yet", int'(commit), 0);
    drive(MV, 0, 1, 0, 0, 0, 0);
    chk("o_placed_held", int'(placed), 1);
    drive(LAND, 0, 0, 0, 0, 0, 0);
    em = '0;
    em[18*10+4] = 1'b1; em[18*10+5] = 1'b1; em[19*10+4] = 1'b1; em[19*10+5] = 1'b1;
    chk("land_commit", int'(commit), 1);
    chk_mask("land_mask", em);
    chk("land_valid", int'(piece_valid), 0);
    drive(LAND, 0, 0, 0, 0, 0, 0);
    chk("land_commit_once", int'(commit), 0);
    chk_mask("land_mask_clear", '0);
    chk("land_placed_level", int'(placed), 1);
    drive(GEN, 3'd2, 0, 0, 0, 0, 0);
    chk("gen_clears_placed", int'(placed), 0);

    // ---- occupied cell blocks a side move
    occ[1*10+2] = 1'b1;
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 1, 0, 0, 0);
    chk("occ_left_blocked", int'(piece_col), 3);
    drive(MV, 0, 0, 0, 1, 0, 0);
    chk("occ_right_ok", int'(piece_col), 4);

    // ---- reset mid-move clears everything at once
    drive(MV, 0, 1, 0, 0, 0, 0);
    chk("pre_reset_row", int'(piece_row), 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clka);
    reset_n = 1'b1;
    occ = '0;

    // ---- top row full: spawn collides, game over sticky until NEWBOARD
    occ[9:0] = '1;
    drive(GEN, 3'd2, 0, 0, 0, 0, 0);
    chk("go_c1", int'(game_over), 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    chk("go_c2", int'(game_over), 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    chk("go_set", int'(game_over), 1);
    chk("go_valid", int'(piece_valid), 0);
    for (int k = 0; k < 3; k++) begin
      drive(GO, 0, 1, 1, 0, 1, 0);
      chk($sformatf("go_hold%0d", k), int'(game_over), 1);
    end
    drive(NB, 0, 0, 0, 0, 0, 0);
    chk("nb_go_clear", int'(game_over), 0);
    chk("nb_placed_clear", int'(placed), 0);
    occ = '0;

`ifdef HARD_DROP_EN
    drive(GEN, 3'd1, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 1);
    chk("hd_enter_row", int'(piece_row), 0);
    for (int k = 0; k < 18; k++) drive(MV, 0, 0, 0, 0, 0, 0);
    chk("hd_row18", int'(piece_row), 18);
    chk("hd_not_placed", int'(placed), 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    chk("hd_placed", int'(placed), 1);
    drive(GEN, 3'd1, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) drive(MV, 0, 0, 1, 0, 0, 0);
    chk("hd_mid_row", int'(piece_row), 5);
    chk("hd_mid_col", int'(piece_col), 3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("hd_rst");
    @(negedge clka);
    reset_n = 1'b1;
`else
    drive(GEN, 3'd1, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    drive(MV, 0, 0, 0, 0, 0, 1);
    chk("drop_ignored_row", int'(piece_row), 0);
    drive(MV, 0, 0, 0, 0, 0, 0);
    chk("drop_ignored_row2", int'(piece_row), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
